pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: DATA_W, 96, payload width in bits (instruction + PC+4 + PC address for the F/D stage).
REQ-002 Parameter: FLUSH_VAL, {DATA_W{1'b0}}, value out_data takes on reset or flush.
REQ-003 Parameter: CNT_W, 16, width of each performance counter.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-006 in_valid  input  1  upstream presents a payload this cycle.
REQ-007 in_ready  output  1  stage accepts the payload this cycle; registered, never combinationally dependent on out_ready.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 flush  input  1  discard all held payloads (branch/exception kill).
REQ-010 out_valid  output  1  out_data holds a live payload.
REQ-011 out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 out_data  output  DATA_W  payload to the downstream stage.
REQ-013 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
REQ-014 bubble_cnt  output  CNT_W  cycles with out_valid=0.

Function
REQ-015 Transfer in: in_valid & in_ready on a rising edge; transfer out: out_valid & out_ready on a rising edge.
REQ-016 Storage: main register (drives out_data) and one skid register; state machine EMPTY (none valid), FULL (main valid), SKID (main and skid valid).
REQ-017 EMPTY: in-transfer -> FULL, main <= in_data; otherwise stay.
REQ-018 FULL: in and out -> FULL, main <= in_data; in only -> SKID, skid <= in_data; out only -> EMPTY; neither -> stay.
REQ-019 SKID: out-transfer -> FULL, main <= skid; no in-transfer possible; otherwise stay, all data held.
REQ-020 in_ready = 1 in EMPTY and FULL, 0 in SKID; out_valid = 1 in FULL and SKID.
REQ-021 Latency in_data -> out_data: one cycle; sustained throughput one payload per cycle with out_ready held high.
REQ-022 Payload order is preserved; no payload is duplicated or dropped except by flush or reset.
REQ-023 flush=1: next state EMPTY, main and skid <= FLUSH_VAL; a coincident in-transfer is discarded; a coincident out-transfer completes normally downstream.
REQ-024 out_data stays stable while out_valid=1 and out_ready=0.
REQ-025 While out_valid=0, out_data equals FLUSH_VAL, or the last consumed payload, or is held; downstream ignores it.

Reset
REQ-026 reset=1 at a clock edge: state EMPTY, main and skid = FLUSH_VAL, in_ready=1 and out_valid=0 from the next cycle; overrides flush and all transfers.
REQ-027 Reset mid-operation discards main and skid contents with no partial update.
REQ-028 stall_cnt and bubble_cnt clear to 0 on reset only, not on flush.

Configuration
REQ-029 Macro PIPE_STAGE_PERF_CNT_EN defined: stall_cnt and bubble_cnt increment per REQ-013/REQ-014 each non-reset cycle and saturate at 2^CNT_W-1.
REQ-030 Macro PIPE_STAGE_PERF_CNT_EN undefined: ports remain, both tied to 0, no counter flops.

Verification
REQ-031 Reset, then in_data=0x00400000_00003004_00003000 with in_valid=1 and out_ready=1 -> next cycle out_valid=1 and out_data equals that value.
REQ-032 out_ready=0, push A=0x1 then B=0x2 -> state SKID, in_ready=0, out_data=0x1; raise out_ready -> 0x1 then 0x2 on consecutive cycles, then out_valid=0.
REQ-033 SKID state with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=FLUSH_VAL; the flushed payload never appears.
REQ-034 Stream 0x10..0x1F with out_ready=1 -> 16 payloads out in order, one per cycle, in_ready held 1.
REQ-035 Perf enabled, CNT_W=4, 20 cycles valid and stalled -> stall_cnt saturates at 15; reset -> 0; flush leaves it unchanged.
REQ-036 reset asserted in the same cycle as flush and an in-transfer in FULL -> next cycle EMPTY, out_data=FLUSH_VAL, counters 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer (EMPTY/FULL/SKID).
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int                 DATA_W    = 96,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}},
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [DATA_W-1:0] main_r, main_s;
  logic [DATA_W-1:0] skid_r, skid_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              in_xfer_s;
  logic              out_xfer_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Next-state and payload routing; flush overrides every transition.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          state_s = ST_FULL;
          main_s  = in_data;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (in_xfer_s && out_xfer_s) begin
          state_s = ST_FULL;
          main_s  = in_data;
        end else if (in_xfer_s) begin
          state_s = ST_SKID;
          skid_s  = in_data;
        end else if (out_xfer_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_FULL;
        end
      end
      ST_SKID: begin
        if (out_xfer_s) begin
          state_s = ST_FULL;
          main_s  = skid_r;
        end else begin
          state_s = ST_SKID;
        end
      end
      default: begin
        state_s = ST_EMPTY;
        main_s  = FLUSH_VAL;
        skid_s  = FLUSH_VAL;
      end
    endcase
    if (flush) begin
      state_s = ST_EMPTY;
      main_s  = FLUSH_VAL;
      skid_s  = FLUSH_VAL;
    end else begin
      state_s = state_s;
    end
  end

  // State, storage and handshake registers; handshakes decode the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_EMPTY;
      main_r      <= FLUSH_VAL;
      skid_r      <= FLUSH_VAL;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= (state_s != ST_SKID);
      out_valid_r <= (state_s != ST_EMPTY);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

`ifdef PIPE_STAGE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_r;
  logic [CNT_W-1:0] bubble_r;

  // Saturating stall/bubble counters; flush does not clear them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r  <= {CNT_W{1'b0}};
      bubble_r <= {CNT_W{1'b0}};
    end else begin
      if (out_valid_r && !out_ready && (stall_r != CNT_MAX)) begin
        stall_r <= stall_r + CNT_ONE;
      end else begin
        stall_r <= stall_r;
      end
      if (!out_valid_r && (bubble_r != CNT_MAX)) begin
        bubble_r <= bubble_r + CNT_ONE;
      end else begin
        bubble_r <= bubble_r;
      end
    end
  end

  assign stall_cnt  = stall_r;
  assign bubble_cnt = bubble_r;
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign bubble_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios plus randomized traffic,
// checked against an occupancy/queue model of the stage.
module tb_pipe_stage_reg;

  localparam int DATA_W = 96;
  localparam int CNT_W  = 4;
  localparam logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_q[$];
  int occ = 0;
  int stall_exp = 0;
  int bubble_exp = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on every output transfer, the presented payload must be the oldest one held.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        chk("out_payload", out_data, exp_q.pop_front());
      end
    end
  end

  // Drive one cycle, advance the model across the edge, then check the DUT.
  task automatic cycle(input logic iv, input logic [DATA_W-1:0] d, input logic fl,
                       input logic ordy, input logic rst);
    bit acc, ox;
    in_valid = iv; in_data = d; flush = fl; out_ready = ordy; reset = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      occ = 0; exp_q.delete(); stall_exp = 0; bubble_exp = 0;
    end else begin
      if (occ > 0 && !ordy && stall_exp < 15) stall_exp++;
      if (occ == 0 && bubble_exp < 15) bubble_exp++;
      acc = iv && (occ < 2) && !fl;
      ox  = (occ > 0) && ordy;
      if (fl) begin
        occ = 0; exp_q.delete();
      end else begin
        occ = occ + int'(acc) - int'(ox);
        if (acc) exp_q.push_back(d);
      end
    end
    chk("in_ready", {95'd0, in_ready}, {95'd0, occ < 2});
    chk("out_valid", {95'd0, out_valid}, {95'd0, occ > 0});
    chk("occupancy", DATA_W'(exp_q.size()), DATA_W'(occ));
    if (occ > 0 && exp_q.size() > 0) chk("out_data_head", out_data, exp_q[0]);
    else if (rst || fl) chk("out_data_flushed", out_data, FLUSH_VAL);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(stall_exp));
    chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(bubble_exp));
`else
    chk("stall_cnt", DATA_W'(stall_cnt), '0);
    chk("bubble_cnt", DATA_W'(bubble_cnt), '0);
`endif
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    // Reset and the first payload passing straight through.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 96'h00400000_00003004_00003000, 1'b0, 1'b1, 1'b0);
    chk("first_payload", out_data, 96'h00400000_00003004_00003000);
    idle(2, 1'b1);

    // Fill main and skid with out_ready low, then drain.
    cycle(1'b1, 96'h1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 96'h2, 1'b0, 1'b0, 1'b0);
    chk("skid_in_ready", {95'd0, in_ready}, 96'd0);
    chk("skid_head", out_data, 96'h1);
    cycle(1'b1, 96'h3, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Flush from SKID with a coincident input.
    cycle(1'b1, 96'h4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 96'h5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 96'h6, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Back-to-back stream at full throughput.
    for (int i = 16; i < 32; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Long stall to exercise counter saturation, then flush keeps counters.
    cycle(1'b1, 96'h7, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    idle(20, 1'b1);

    // Reset together with flush and an input transfer while FULL.
    cycle(1'b1, 96'h8, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 96'h9, 1'b1, 1'b1, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rd = {$urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 9) < 7), rd, ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end
    idle(4, 1'b1);
    chk("drained", DATA_W'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
